// File: rtl/gb_sram_wr_ctrl.sv
// Global-buffer SRAM write controller: packs input beats into SRAM words, fills one bank per
// pass, then marks it full and rotates to the next bank so the reader can drain it.
`timescale 1ns/1ps
module gb_sram_wr_ctrl #(
    parameter int SRAM_ADDRWIDTH = 9,
    parameter int DATA_WIDTH     = 8,
    parameter int PORT_SEP       = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              IFSRAM_val,
    output logic                              SRAMIF_rdy,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic [3:0]                        SRAM_num,
    input  logic [SRAM_ADDRWIDTH:0]           wr_num,
    output logic                              write_en,
    output logic [SRAM_ADDRWIDTH-1:0]         addr_Wr,
    output logic [(DATA_WIDTH<<PORT_SEP)-1:0] data_Wr,
    output logic [3:0]                        Wr_ID,
    input  logic [3:0]                        Rd_ID,
    output logic                              SRAM_prepare,
    input  logic                              read_SRAM_done,
    output logic                              write_SRAM_done
);

    localparam int BEATS  = 1 << PORT_SEP;
    localparam int WORD_W = DATA_WIDTH << PORT_SEP;
    localparam int BEAT_W = (PORT_SEP > 0) ? PORT_SEP : 1;
    localparam int CNT_W  = SRAM_ADDRWIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b11
    } state_e;

    state_e                    state_q,     state_d;
    logic [BEAT_W-1:0]         beat_cnt_q,  beat_cnt_d;
    logic [CNT_W-1:0]          word_cnt_q,  word_cnt_d;
    logic [CNT_W-1:0]          wr_num_q,    wr_num_d;
    logic [WORD_W-1:0]         pack_q,      pack_d;
    logic                      write_en_q,  write_en_d;
    logic [SRAM_ADDRWIDTH-1:0] addr_q,      addr_d;
    logic [WORD_W-1:0]         data_q,      data_d;
    logic [3:0]                wr_id_q,     wr_id_d;
    logic [15:0]               bank_full_q, bank_full_d;

    logic       beat_hs;
    logic       last_beat;
    logic       last_word;
    logic [3:0] num_banks;

    assign num_banks = (SRAM_num == 4'd0) ? 4'd1 : SRAM_num;
    assign beat_hs   = IFSRAM_val && (state_q == WRITE);
    assign last_beat = (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign last_word = (word_cnt_q == wr_num_q - CNT_W'(1));

    always_comb begin
        // NOTE: every next-state value defaults to its hold value first, so no path infers a latch.
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        word_cnt_d  = word_cnt_q;
        wr_num_d    = wr_num_q;
        pack_d      = pack_q;
        write_en_d  = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_id_d     = wr_id_q;
        bank_full_d = bank_full_q;

        case (state_q)
            IDLE: begin
                if (!bank_full_q[wr_id_q]) begin
                    state_d    = WRITE;
                    wr_num_d   = (wr_num == '0) ? CNT_W'(1) : wr_num;
                    word_cnt_d = '0;
                end
            end
            WRITE: begin
                if (beat_hs) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (beat_cnt_q == BEAT_W'(k)) pack_d[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
                    end
                    beat_cnt_d = last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
                    if (last_beat) begin
                        write_en_d = 1'b1;
                        addr_d     = word_cnt_q[SRAM_ADDRWIDTH-1:0];
                        data_d     = pack_d;
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        if (last_word) state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                word_cnt_d = '0;
                // >= also catches a Wr_ID left beyond a since-lowered SRAM_num
                wr_id_d    = (wr_id_q >= num_banks - 4'd1) ? 4'd0 : wr_id_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase

        // Clear first so a same-bank set in the DONE cycle wins
        if (read_SRAM_done)   bank_full_d[Rd_ID]   = 1'b0;
        if (state_q == DONE)  bank_full_d[wr_id_q] = 1'b1;

        if (start) begin
            state_d     = IDLE;
            beat_cnt_d  = '0;
            word_cnt_d  = '0;
            wr_num_d    = '0;
            pack_d      = '0;
            write_en_d  = 1'b0;
            addr_d      = '0;
            data_d      = '0;
            wr_id_d     = 4'd0;
            bank_full_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            word_cnt_q  <= '0;
            wr_num_q    <= '0;
            pack_q      <= '0;
            write_en_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_id_q     <= 4'd0;
            bank_full_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            word_cnt_q  <= word_cnt_d;
            wr_num_q    <= wr_num_d;
            pack_q      <= pack_d;
            write_en_q  <= write_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_id_q     <= wr_id_d;
            bank_full_q <= bank_full_d;
        end
    end

    assign SRAMIF_rdy      = (state_q == WRITE);
    assign write_SRAM_done = (state_q == DONE);
    assign write_en        = write_en_q;
    assign addr_Wr         = addr_q;
    assign data_Wr         = data_q;
    assign Wr_ID           = wr_id_q;
    assign SRAM_prepare    = bank_full_q[Rd_ID];

endmodule

// File: tb/tb_gb_sram_wr_ctrl.sv
// Bench for gb_sram_wr_ctrl: directed phases with randomized beats, checked every cycle
// against a transaction-level model of bank filling, packing and bank ownership.
`timescale 1ns/1ps
module tb_gb_sram_wr_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int PS    = 1;
    localparam int BEATS = 1 << PS;
    localparam int WW    = DW << PS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          val = 1'b0;
    logic          rdy;
    logic [DW-1:0] din = '0;
    logic [3:0]    snum = 4'd2;
    logic [AW:0]   wnum = 10'd4;
    logic          we;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
    logic [3:0]    wr_id;
    logic [3:0]    rdid = 4'd0;
    logic          prep;
    logic          rdone = 1'b0;
    logic          wdone;

    gb_sram_wr_ctrl #(.SRAM_ADDRWIDTH(AW), .DATA_WIDTH(DW), .PORT_SEP(PS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .IFSRAM_val(val), .SRAMIF_rdy(rdy),
        .data_in(din), .SRAM_num(snum), .wr_num(wnum), .write_en(we), .addr_Wr(addr),
        .data_Wr(wdata), .Wr_ID(wr_id), .Rd_ID(rdid), .SRAM_prepare(prep),
        .read_SRAM_done(rdone), .write_SRAM_done(wdone)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: accepted beats queue up until a word is complete; a fill is a run of
    // wr_num words into one bank, followed by a one-cycle done gap and a one-cycle idle gap.
    bit          m_rdy = 0, m_done = 0, m_we = 0, m_idle = 1, m_hs = 0;
    logic [AW-1:0] m_addr = '0;
    logic [WW-1:0] m_data = '0;
    logic [3:0]  m_wrid = '0;
    bit   [15:0] m_full = '0;
    int          widx = 0, m_wrn = 1;
    logic [DW-1:0] pend[$];
    logic [WW-1:0] wlog[$];
    logic [AW-1:0] alog[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit [15:0] old_full;
        int nb;
        m_hs = 0;
        m_we = 0;
        if (!rst_n || start) begin
            m_rdy = 0; m_done = 0; m_idle = 1; m_addr = '0; m_data = '0;
            m_wrid = '0; m_full = '0; widx = 0;
            pend.delete();
            return;
        end
        old_full = m_full;
        nb = (snum == 4'd0) ? 1 : int'(snum);
        if (rdone) m_full[rdid] = 1'b0;
        if (m_done) begin
            m_full[m_wrid] = 1'b1;
            m_wrid = (int'(m_wrid) >= nb - 1) ? 4'd0 : m_wrid + 4'd1;
            m_done = 0; m_idle = 1; widx = 0;
        end else if (m_idle) begin
            if (!old_full[m_wrid]) begin
                m_idle = 0; m_rdy = 1; widx = 0;
                m_wrn = (wnum == '0) ? 1 : int'(wnum);
            end
        end else if (m_rdy && val) begin
            m_hs = 1;
            pend.push_back(din);
            if (pend.size() == BEATS) begin
                m_we = 1;
                m_addr = AW'(widx);
                for (int i = 0; i < BEATS; i++) m_data[i*DW +: DW] = pend[i];
                pend.delete();
                if (widx == m_wrn - 1) begin
                    m_done = 1; m_rdy = 0;
                end else begin
                    widx++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        if (we) begin
            wlog.push_back(wdata);
            alog.push_back(addr);
        end
        check("write_en", 32'(we), 32'(m_we));
        if (m_we) check("addr_Wr", 32'(addr), 32'(m_addr));
        check("data_Wr", 32'(wdata), 32'(m_data));
        check("SRAMIF_rdy", 32'(rdy), 32'(m_rdy));
        check("write_SRAM_done", 32'(wdone), 32'(m_done));
        check("Wr_ID", 32'(wr_id), 32'(m_wrid));
        check("SRAM_prepare", 32'(prep), 32'(m_full[rdid]));
    endtask

    task automatic pulse_start();
        start = 1'b1; val = 1'b0; rdone = 1'b0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [WW-1:0] exp_words[4];
        logic [DW-1:0] beat_no;
        int            got;
        exp_words = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_data", 32'(wdata), 32'd0);
        rst_n = 1'b1;

        // Full-rate fill of both banks, then all-full stall
        snum = 4'd2; wnum = 10'd4; rdid = 4'd0; val = 1'b1; beat_no = 8'd1;
        wlog.delete(); alog.delete();
        for (int i = 0; i < 26; i++) begin
            din = beat_no;
            tick();
            if (m_hs) beat_no = beat_no + 8'd1;
        end
        check("t1_nwrites", 32'(wlog.size()), 32'd8);
        if (wlog.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_word", 32'(wlog[i]), 32'(exp_words[i]));
                check("t1_addr", 32'(alog[i]), 32'(i));
            end
        end
        check("t1_wr_id", 32'(wr_id), 32'd0);
        check("t1_prepare", 32'(prep), 32'd1);
        check("t3_stall_rdy", 32'(rdy), 32'd0);

        // Reader frees bank 0; writing resumes there at address 0
        rdone = 1'b1; rdid = 4'd0;
        tick();
        rdone = 1'b0;
        wlog.delete(); alog.delete();
        for (int i = 0; i < 14; i++) begin
            din = 8'($urandom);
            tick();
        end
        check("t3_resume_addr", (alog.size() > 0) ? 32'(alog[0]) : 32'hFFFF_FFFF, 32'd0);

        // Toggling valid
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            val = i[0] ? 1'b0 : 1'b1;
            din = 8'($urandom);
            if (i == 30) begin rdone = 1'b1; rdid = 4'd0; end
            else rdone = 1'b0;
            tick();
        end

        // start after 3 beats discards the partial word
        pulse_start();
        val = 1'b1; got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            din = 8'($urandom);
            tick();
            if (m_hs) got++;
        end
        check("t4_beats", 32'(got), 32'd3);
        din = 8'hEE;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_no_write", 32'(we), 32'd0);
        for (int i = 0; i < 6; i++) begin
            din = 8'($urandom);
            tick();
        end

        // Reset pulse mid-write
        for (int i = 0; i < 3; i++) begin din = 8'($urandom); tick(); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin din = 8'($urandom); tick(); end

        // Three-bank rotation with one-word fills and a draining reader
        pulse_start();
        snum = 4'd3; wnum = 10'd1;
        for (int i = 0; i < 200; i++) begin
            val = 1'($urandom);
            din = 8'($urandom);
            rdone = ($urandom_range(0, 2) == 0);
            rdid = 4'($urandom_range(0, 2));
            tick();
        end

        // Random configuration, including 0 banks / 0 words and lowered bank counts
        for (int i = 0; i < 900; i++) begin
            if ((i % 150) == 0) begin
                snum = 4'($urandom_range(0, 5));
                wnum = 10'($urandom_range(0, 6));
            end
            start = ($urandom_range(0, 120) == 0);
            val = ($urandom_range(0, 3) != 0);
            din = 8'($urandom);
            rdone = ($urandom_range(0, 3) == 0);
            rdid = 4'($urandom_range(0, 5));
            tick();
        end
        start = 1'b0;

        // Largest fill covers every address
        pulse_start();
        snum = 4'd1; wnum = 10'd512; rdid = 4'd0; val = 1'b1;
        wlog.delete(); alog.delete();
        for (int i = 0; i < 1032; i++) begin
            din = 8'($urandom);
            tick();
        end
        check("big_nwrites", 32'(alog.size()), 32'd512);
        check("big_last_addr", (alog.size() > 0) ? 32'(alog[alog.size()-1]) : 32'hFFFF_FFFF, 32'd511);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
